code_range_checker: RTL and testbench

Parametrised, pipelined successor to the 4-bit "code > 9" comparator. Accepts a stream of WIDTH-bit codes (Gray or plain binary), converts to binary, compares against a runtime threshold under a selectable mode, and emits binary value plus flag over a valid/ready handshake. Tracks out-of-range events in a saturating counter and a sticky error bit. Sits between the Gray decoder front end and the BCD display path, replacing the combinational comparator.

---
 rtl/code_cmp_pkg.sv | 28 ++
 rtl/code_range_checker_if.sv | 24 ++
 rtl/gray_to_bin.sv | 14 +
 rtl/code_range_checker.sv | 91 +++++++++
 tb/tb_code_range_checker.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/code_cmp_pkg.sv
// rtl/code_cmp_pkg.sv - compare modes and the unsigned compare helper for code_range_checker
package code_cmp_pkg;

  localparam int CMP_MAX_W = 32;

  typedef enum logic [1:0] {
    CMP_GT = 2'b00,
    CMP_GE = 2'b01,
    CMP_LT = 2'b10,
    CMP_EQ = 2'b11
  } cmp_mode_e;

  // Callers zero-extend both operands to CMP_MAX_W, so any WIDTH up to 32 compares unsigned.
  function automatic logic cmp_eval(input logic [CMP_MAX_W-1:0] a,
                                    input logic [CMP_MAX_W-1:0] b,
                                    input cmp_mode_e            m);
    logic r;
    case (m)
      CMP_GT:  r = (a > b);
      CMP_GE:  r = (a >= b);
      CMP_LT:  r = (a < b);
      CMP_EQ:  r = (a == b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/code_range_checker_if.sv
// rtl/code_range_checker_if.sv - input/output handshake bundle of code_range_checker
interface code_range_checker_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_code;
  logic [WIDTH-1:0] limit;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_bin;
  logic             out_flag;

  modport master (
    output in_valid, in_code, limit, mode, out_ready,
    input  in_ready, out_valid, out_bin, out_flag
  );

  modport slave (
    input  in_valid, in_code, limit, mode, out_ready,
    output in_ready, out_valid, out_bin, out_flag
  );
endinterface

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - combinational Gray to binary conversion
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // b[i] is the XOR of all Gray bits from i upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^(gray_i >> i);
  end

endmodule

// File: rtl/code_range_checker.sv
// rtl/code_range_checker.sv - two-stage code/threshold compare pipeline with error counter
module code_range_checker
  import code_cmp_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8,
  parameter int GRAY_IN   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  code_range_checker_if.slave  bus,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 sticky_err
);

  logic [WIDTH-1:0]     bin_w;
  logic                 s1_valid_q, s2_valid_q;
  logic [WIDTH-1:0]     s1_bin_q, s1_limit_q, s2_bin_q;
  cmp_mode_e            s1_mode_q;
  logic                 s2_flag_q;
  logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
  logic                 sticky_q, sticky_d;
  logic                 en1, en2, accept, flag_hs;

  if (GRAY_IN != 0) begin : g_gray
    gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
      .gray_i (bus.in_code),
      .bin_o  (bin_w)
    );
  end else begin : g_plain
    assign bin_w = bus.in_code;
  end

  // Each stage advances when it is empty or the stage after it is moving.
  assign en2          = !s2_valid_q || bus.out_ready;
  assign en1          = !s1_valid_q || en2;
  assign accept       = bus.in_valid && en1;
  assign flag_hs      = s2_valid_q && bus.out_ready && s2_flag_q;
  assign bus.in_ready = en1;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_bin   = s2_bin_q;
  assign bus.out_flag  = s2_flag_q;
  assign err_count     = err_count_q;
  assign sticky_err    = sticky_q;

  always_comb begin
    err_count_d = err_count_q;
    sticky_d    = sticky_q;
    if (clr) begin
      err_count_d = '0;
      sticky_d    = 1'b0;
    end else if (flag_hs) begin
      if (err_count_q != {CNT_WIDTH{1'b1}}) err_count_d = err_count_q + CNT_WIDTH'(1);
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_bin_q    <= '0;
      s1_limit_q  <= '0;
      s1_mode_q   <= CMP_GT;
      s2_valid_q  <= 1'b0;
      s2_bin_q    <= '0;
      s2_flag_q   <= 1'b0;
      err_count_q <= '0;
      sticky_q    <= 1'b0;
    end else begin
      if (en1) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_bin_q   <= bin_w;
          s1_limit_q <= bus.limit;
          s1_mode_q  <= cmp_mode_e'(bus.mode);
        end
      end
      if (en2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_bin_q  <= s1_bin_q;
          s2_flag_q <= cmp_eval(CMP_MAX_W'(s1_bin_q), CMP_MAX_W'(s1_limit_q), s1_mode_q);
        end
      end
      err_count_q <= err_count_d;
      sticky_q    <= sticky_d;
    end
  end

endmodule

// File: tb/tb_code_range_checker.sv
// tb/tb_code_range_checker.sv - directed vector bench for code_range_checker
module tb_code_range_checker;
  import code_cmp_pkg::*;

  typedef struct {
    logic [3:0] code;
    logic [3:0] limit;
    logic [1:0] mode;
    logic [3:0] exp_bin;
    logic       exp_flag;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       clr_a, clr_b;
  logic [1:0] err_a;
  logic [7:0] err_b;
  logic       sticky_a, sticky_b;
  int         total, bad;
  vec_t       tab [13];

  code_range_checker_if #(.WIDTH(4)) bus_a ();
  code_range_checker_if #(.WIDTH(4)) bus_b ();

  code_range_checker #(.WIDTH(4), .CNT_WIDTH(2), .GRAY_IN(0)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr_a),
    .bus        (bus_a),
    .err_count  (err_a),
    .sticky_err (sticky_a)
  );

  code_range_checker #(.WIDTH(4), .CNT_WIDTH(8), .GRAY_IN(1)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr_b),
    .bus        (bus_b),
    .err_count  (err_b),
    .sticky_err (sticky_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_in(input bit sel, input logic v, input logic [3:0] code,
                        input logic [3:0] lim, input logic [1:0] md, input logic rdy);
    if (sel) begin
      bus_b.in_valid = v; bus_b.in_code = code; bus_b.limit = lim;
      bus_b.mode = md; bus_b.out_ready = rdy;
    end else begin
      bus_a.in_valid = v; bus_a.in_code = code; bus_a.limit = lim;
      bus_a.mode = md; bus_a.out_ready = rdy;
    end
  endtask

  function automatic logic [31:0] get_ov(input bit sel);
    return sel ? 32'(bus_b.out_valid) : 32'(bus_a.out_valid);
  endfunction
  function automatic logic [31:0] get_bin(input bit sel);
    return sel ? 32'(bus_b.out_bin) : 32'(bus_a.out_bin);
  endfunction
  function automatic logic [31:0] get_flag(input bit sel);
    return sel ? 32'(bus_b.out_flag) : 32'(bus_a.out_flag);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Streams tab[start..start+n-1] back to back; word c must be on the output in cycle c+2.
  task automatic run_table(input bit sel, input int start, input int n);
    for (int c = 0; c < n + 2; c++) begin
      if (c < n) set_in(sel, 1'b1, tab[start+c].code, tab[start+c].limit, tab[start+c].mode, 1'b1);
      else       set_in(sel, 1'b0, 4'd0, 4'd0, 2'd0, 1'b1);
      #2;
      if (c == 1) chk("latency_not_early", get_ov(sel), 0);
      if (c >= 2) begin
        chk("out_valid", get_ov(sel), 1);
        chk($sformatf("out_bin[%0d]", start+c-2), get_bin(sel), 32'(tab[start+c-2].exp_bin));
        chk($sformatf("out_flag[%0d]", start+c-2), get_flag(sel), 32'(tab[start+c-2].exp_flag));
      end
      next_cycle();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    tab[0]  = '{4'd6,  4'd9, CMP_GT, 4'd6,  1'b0};
    tab[1]  = '{4'd9,  4'd9, CMP_GT, 4'd9,  1'b0};
    tab[2]  = '{4'd12, 4'd9, CMP_GT, 4'd12, 1'b1};
    tab[3]  = '{4'd1,  4'd9, CMP_GT, 4'd1,  1'b0};
    tab[4]  = '{4'd15, 4'd9, CMP_GT, 4'd15, 1'b1};
    tab[5]  = '{4'd9,  4'd9, CMP_GT, 4'd9,  1'b0};
    tab[6]  = '{4'd9,  4'd9, CMP_GE, 4'd9,  1'b1};
    tab[7]  = '{4'd9,  4'd9, CMP_LT, 4'd9,  1'b0};
    tab[8]  = '{4'd9,  4'd9, CMP_EQ, 4'd9,  1'b1};
    tab[9]  = '{4'd8,  4'd9, CMP_LT, 4'd8,  1'b1};
    tab[10] = '{4'b1101, 4'd9, CMP_EQ, 4'b1001, 1'b1};
    tab[11] = '{4'b1111, 4'd9, CMP_EQ, 4'b1010, 1'b0};
    tab[12] = '{4'd15, 4'd9, CMP_GT, 4'd15, 1'b1};

    rst_n = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    set_in(1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b1);
    set_in(1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b1);
    #1;
    chk("rst_out_valid", get_ov(0), 0);
    chk("rst_out_bin", get_bin(0), 0);
    chk("rst_out_flag", get_flag(0), 0);
    chk("rst_err_count", 32'(err_a), 0);
    chk("rst_sticky", 32'(sticky_a), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rst_in_ready", 32'(bus_a.in_ready), 1);

    // binary GT stream, then every mode at the boundary; CNT_WIDTH=2 saturates at 3
    run_table(1'b0, 0, 5);
    #2;
    chk("err_after_gt", 32'(err_a), 2);
    chk("sticky_after_gt", 32'(sticky_a), 1);
    next_cycle();
    run_table(1'b0, 5, 5);
    #2;
    chk("err_saturated", 32'(err_a), 3);
    next_cycle();

    // Gray input instance
    run_table(1'b1, 10, 2);
    #2;
    chk("gray_err", 32'(err_b), 1);
    chk("gray_sticky", 32'(sticky_b), 1);
    next_cycle();

    // backpressure: four stalled cycles with codes 1,2,3 offered
    set_in(0, 1, 4'd1, 4'd9, CMP_GT, 0); #2;
    chk("bp0_in_ready", 32'(bus_a.in_ready), 1);
    next_cycle();
    set_in(0, 1, 4'd2, 4'd9, CMP_GT, 0); #2;
    chk("bp1_in_ready", 32'(bus_a.in_ready), 1);
    chk("bp1_out_valid", get_ov(0), 0);
    next_cycle();
    set_in(0, 1, 4'd3, 4'd9, CMP_GT, 0); #2;
    chk("bp2_in_ready", 32'(bus_a.in_ready), 0);
    chk("bp2_out_valid", get_ov(0), 1);
    chk("bp2_out_bin", get_bin(0), 1);
    next_cycle();
    #2;
    chk("bp3_in_ready", 32'(bus_a.in_ready), 0);
    chk("bp3_out_bin_held", get_bin(0), 1);
    next_cycle();
    set_in(0, 1, 4'd3, 4'd9, CMP_GT, 1); #2;
    chk("bp4_in_ready_comb", 32'(bus_a.in_ready), 1);
    chk("bp4_out_bin", get_bin(0), 1);
    next_cycle();
    set_in(0, 0, 4'd0, 4'd9, CMP_GT, 1); #2;
    chk("bp5_out_valid", get_ov(0), 1);
    chk("bp5_out_bin", get_bin(0), 2);
    next_cycle();
    #2;
    chk("bp6_out_valid", get_ov(0), 1);
    chk("bp6_out_bin", get_bin(0), 3);
    next_cycle();
    #2;
    chk("bp7_drained", get_ov(0), 0);
    chk("bp_err_unchanged", 32'(err_a), 3);
    next_cycle();

    // clr coincident with a flagged handshake wins
    set_in(0, 1, 4'd15, 4'd9, CMP_GT, 1);
    next_cycle();
    set_in(0, 0, 4'd0, 4'd9, CMP_GT, 1);
    next_cycle();
    clr_a = 1'b1; #2;
    chk("clr_hs_valid", get_ov(0), 1);
    chk("clr_hs_flag", get_flag(0), 1);
    next_cycle();
    clr_a = 1'b0; #2;
    chk("clr_err", 32'(err_a), 0);
    chk("clr_sticky", 32'(sticky_a), 0);
    next_cycle();
    run_table(1'b0, 12, 1);
    #2;
    chk("post_clr_err", 32'(err_a), 1);
    chk("post_clr_sticky", 32'(sticky_a), 1);
    next_cycle();

    // reset with two words stalled in the pipeline
    set_in(0, 1, 4'd15, 4'd9, CMP_GT, 0);
    next_cycle();
    next_cycle();
    set_in(0, 0, 4'd0, 4'd9, CMP_GT, 0); #2;
    chk("inflight_valid", get_ov(0), 1);
    chk("inflight_in_ready", 32'(bus_a.in_ready), 0);
    rst_n = 1'b0; #1;
    chk("midrst_out_valid", get_ov(0), 0);
    chk("midrst_err", 32'(err_a), 0);
    chk("midrst_sticky", 32'(sticky_a), 0);
    chk("midrst_out_bin", get_bin(0), 0);
    next_cycle();
    rst_n = 1'b1;
    set_in(0, 0, 4'd0, 4'd9, CMP_GT, 1); #1;
    chk("midrst_in_ready", 32'(bus_a.in_ready), 1);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("no_stale_output", get_ov(0), 0);
      chk("no_stale_err", 32'(err_a), 0);
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
